// File: rtl/nwd_seq.sv
// nwd_seq: valid/ready sequencer in front of the subtraction GCD core.
// Accepts operand pairs, starts the core, counts its steps and returns
// the result. Pairs with a zero operand are answered locally because the
// core would never reach a == b for them.
module nwd_seq #(
   parameter int W  = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_x,
   input  logic [W-1:0]  in_y,
   output logic          nwd_ini,
   output logic [W-1:0]  nwd_x,
   output logic [W-1:0]  nwd_y,
   input  logic [W-1:0]  nwd_o,
   input  logic          nwd_fin,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_gcd,
   output logic [CW-1:0] out_cycles
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [W-1:0]  op_x;
   logic [W-1:0]  op_y;
   logic [CW-1:0] cnt;

   // Handshake flags and the core strobe are pure state decodes, so there
   // is no combinational path from in_valid/out_ready to any output.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign nwd_ini   = (state == LOAD);
   // The operand registers feed the core directly; they only change on
   // accept, so the core sees stable values for the whole job.
   assign nwd_x     = op_x;
   assign nwd_y     = op_y;

   // Job sequencing: accept, load core, count steps until fin, hold result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_x       <= '0;
         op_y       <= '0;
         cnt        <= '0;
         out_gcd    <= '0;
         out_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_x <= in_x;
                  op_y <= in_y;
                  cnt  <= '0;
                  if (in_x == '0 || in_y == '0) begin
                     // gcd(0,y) = y and gcd(0,0) = 0; the core is never started.
                     out_gcd    <= in_x | in_y;
                     out_cycles <= '0;
                     state      <= DONE;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               // fin here still reflects the previous job; ignore it.
               state <= RUN;
            end
            RUN: begin
               if (nwd_fin) begin
                  out_gcd    <= nwd_o;
                  out_cycles <= cnt;
                  state      <= DONE;
               end else if (cnt != {CW{1'b1}}) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // DONE: result held until the consumer takes it. Returning to
               // IDLE first guarantees a gap cycle before the next accept.
               if (out_ready) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/nwd_seq.md
Name: nwd_seq

Overview:
- Handshaking sequencer that sits directly in front of the NWD (GCD) core.
- Accepts operand pairs over a valid/ready interface and drives the core's ini/x/y inputs.
- Watches the core's fin/o outputs, captures the result plus an iteration count, and presents them on a valid/ready output.
- Shields the core from zero operands: the subtraction core never terminates when exactly one operand is 0, so those pairs are bypassed here.

Parameters:
- W, 16, operand/result width; must match the core's x/y/o width.
- CW, 16, width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_x  in  W  first operand.
- in_y  in  W  second operand.
- nwd_ini  out  1  load strobe to core.
- nwd_x  out  W  operand x to core.
- nwd_y  out  W  operand y to core.
- nwd_o  in  W  core result (core's register a).
- nwd_fin  in  1  core done flag (a == b).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  W  GCD result.
- out_cycles  out  CW  number of core subtraction steps taken.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; nwd_ini=0; nwd_x=0; nwd_y=0; out_gcd=0; out_cycles=0.
- The core has no reset. The sequencer ignores nwd_fin/nwd_o outside RUN.
- FSM states: IDLE, LOAD, RUN, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are purely state-decoded, with no combinational path from in_valid or out_ready.
- IDLE:
  - On in_valid && in_ready, latch in_x/in_y into op_x/op_y and clear the counter.
  - If in_x==0 or in_y==0: out_gcd <= in_x | in_y (gcd(0,y)=y, gcd(0,0)=0), out_cycles <= 0, go to DONE. The core is not started.
  - Otherwise go to LOAD.
- LOAD: nwd_ini=1, nwd_x=op_x, nwd_y=op_y for exactly one cycle. The core loads on the next edge. nwd_fin in this cycle is stale and must be ignored. Next state is RUN.
- RUN: nwd_ini=0; nwd_x/nwd_y keep their values (don't care to the core).
  - If nwd_fin=1: out_gcd <= nwd_o, out_cycles <= counter, go to DONE.
  - Else: counter <= counter+1, saturating at 2^CW-1.
- DONE: out_gcd/out_cycles are held stable while out_valid=1. On out_ready, go to IDLE.
- A new pair is never accepted in the same cycle a result is released. This gives one idle cycle minimum between jobs.
- Latency, measured from the accept edge:
  - Nonzero operands: out_valid rises after cycles+3 edges (1 for LOAD, 1 for core load, cycles+1 in RUN).
  - Zero-bypass: out_valid rises after 1 edge.
- Equal nonzero operands give cycles=0, with fin seen in the first RUN cycle.
- Reset mid-operation: the FSM returns to IDLE immediately. The core's state is left as-is and ignored. The next job's LOAD reinitialises it.
- in_x/in_y changes while in_ready=0 have no effect.
- out_ready asserted outside DONE has no effect.
- Width: all arithmetic is unsigned W-bit. The counter never wraps.

Test Plan:
- Pair (12,18), out_ready=1 -> out_gcd=6, out_cycles=2, out_valid 5 edges after accept; nwd_ini high for exactly one cycle.
- Pairs (0,7), (9,0), (0,0) -> out_gcd=7, 9, 0 respectively, out_cycles=0, out_valid 1 edge after accept; nwd_ini never asserted.
- Pair (5,5) -> out_gcd=5, out_cycles=0. Stale nwd_fin=1 left over from a previous job during LOAD must not end the job early: precede with (4,4) and follow with (21,14) -> (21,14) gives 7, cycles 2.
- Pair (65535,1) -> out_gcd=1, out_cycles=65534; in_ready stays 0 throughout and in_valid toggling is ignored.
- Backpressure: (48,36) with out_ready held low 4 cycles after out_valid -> out_gcd=12 and out_cycles=3 stay stable; release on out_ready; in_ready returns 1 the following cycle.
- Assert rst asynchronously in the middle of RUN for (1000,3) -> all outputs return to reset values immediately. A subsequent (8,12) gives 4, cycles 2.
